// File: rtl/router_egress_arbiter.sv
// Packet-granular round-robin arbiter draining three router FIFOs onto one
// valid/ready egress link, with per-FIFO stall timeout and soft-reset pulses.
module router_egress_arbiter #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] fifo_dout_0,
    input  logic [DATA_W-1:0] fifo_dout_1,
    input  logic [DATA_W-1:0] fifo_dout_2,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    output logic              rd_en_0,
    output logic              rd_en_1,
    output logic              rd_en_2,
    output logic              soft_rst_0,
    output logic              soft_rst_1,
    output logic              soft_rst_2,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sop,
    output logic              out_eop,
    output logic [2:0]        grant,
    output logic              busy
);

    localparam int STALL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, PARITY} state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [1:0]         rrPtr_q, rrPtr_d;
    logic [5:0]         lenCnt_q, lenCnt_d;
    logic [STALL_W-1:0] stallCnt_q, stallCnt_d;
    logic [2:0]         softRst_q, softRst_d;

    logic [DATA_W-1:0]  selData;
    logic               selEmpty;
    logic [1:0]         gntIdx;
    logic [2:0]         pick;
    logic               active;
    logic               xfer;
    logic               stall;
    logic               timeout;

    // Search starts one past the last owner, wrapping modulo three.
    function automatic logic [2:0] rrPick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] r;
        r = 3'b000;
        case (ptr)
            2'd0: begin
                if (req[1])      r = 3'b010;
                else if (req[2]) r = 3'b100;
                else if (req[0]) r = 3'b001;
            end
            2'd1: begin
                if (req[2])      r = 3'b100;
                else if (req[0]) r = 3'b001;
                else if (req[1]) r = 3'b010;
            end
            default: begin
                if (req[0])      r = 3'b001;
                else if (req[1]) r = 3'b010;
                else if (req[2]) r = 3'b100;
            end
        endcase
        return r;
    endfunction

    always_comb begin
        selData  = '0;
        selEmpty = 1'b1;
        gntIdx   = 2'd0;
        case (grant_q)
            3'b001: begin selData = fifo_dout_0; selEmpty = fifo_empty_0; gntIdx = 2'd0; end
            3'b010: begin selData = fifo_dout_1; selEmpty = fifo_empty_1; gntIdx = 2'd1; end
            3'b100: begin selData = fifo_dout_2; selEmpty = fifo_empty_2; gntIdx = 2'd2; end
            default: ;
        endcase
    end

    assign pick    = rrPick({!fifo_empty_2, !fifo_empty_1, !fifo_empty_0}, rrPtr_q);
    assign active  = (state_q != IDLE);
    assign xfer    = active && !selEmpty && out_ready;
    assign stall   = active && !selEmpty && !out_ready;
    assign timeout = stall && (stallCnt_q == STALL_W'(TIMEOUT - 1));

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rrPtr_d    = rrPtr_q;
        lenCnt_d   = lenCnt_q;
        stallCnt_d = stallCnt_q;
        softRst_d  = 3'b000;
        case (state_q)
            IDLE: begin
                stallCnt_d = '0;
                if (pick != 3'b000) begin
                    grant_d = pick;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (xfer) begin
                    lenCnt_d = selData[7:2];
                    state_d  = (selData[7:2] == 6'd0) ? PARITY : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (xfer) begin
                    if (lenCnt_q != 6'd0) lenCnt_d = lenCnt_q - 6'd1;
                    if (lenCnt_q <= 6'd1) state_d = PARITY;
                end
            end
            PARITY: begin
                if (xfer) begin
                    rrPtr_d = gntIdx;
                    grant_d = 3'b000;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A transfer always beats a timeout that would fire on the same cycle.
        if (active) begin
            if (xfer) begin
                stallCnt_d = '0;
            end else if (timeout) begin
                softRst_d  = grant_q;
                rrPtr_d    = gntIdx;
                grant_d    = 3'b000;
                stallCnt_d = '0;
                state_d    = IDLE;
            end else if (stall) begin
                stallCnt_d = stallCnt_q + STALL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 3'b000;
            rrPtr_q    <= 2'd2;
            lenCnt_q   <= 6'd0;
            stallCnt_q <= '0;
            softRst_q  <= 3'b000;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rrPtr_q    <= rrPtr_d;
            lenCnt_q   <= lenCnt_d;
            stallCnt_q <= stallCnt_d;
            softRst_q  <= softRst_d;
        end
    end

    assign out_data   = active ? selData : '0;
    assign out_valid  = active && !selEmpty;
    assign out_sop    = out_valid && (state_q == HDR);
    assign out_eop    = out_valid && (state_q == PARITY);
    assign rd_en_0    = xfer && grant_q[0];
    assign rd_en_1    = xfer && grant_q[1];
    assign rd_en_2    = xfer && grant_q[2];
    assign soft_rst_0 = softRst_q[0];
    assign soft_rst_1 = softRst_q[1];
    assign soft_rst_2 = softRst_q[2];
    assign grant      = grant_q;
    assign busy       = active;

endmodule

// File: tb/tb_router_egress_arbiter.sv
// Directed bench for router_egress_arbiter: FIFO queues feed the DUT and every
// observed output is compared against hand-computed values.
module tb_router_egress_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] fifo_dout_0, fifo_dout_1, fifo_dout_2;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       rd_en_0, rd_en_1, rd_en_2;
    logic       soft_rst_0, soft_rst_1, soft_rst_2;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_sop;
    logic       out_eop;
    logic [2:0] grant;
    logic       busy;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    int testsRun;
    int testsFailed;

    router_egress_arbiter #(.DATA_W(8), .TIMEOUT(30)) dut (
        .clk(clk), .rst(rst),
        .fifo_dout_0(fifo_dout_0), .fifo_dout_1(fifo_dout_1), .fifo_dout_2(fifo_dout_2),
        .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
        .rd_en_0(rd_en_0), .rd_en_1(rd_en_1), .rd_en_2(rd_en_2),
        .soft_rst_0(soft_rst_0), .soft_rst_1(soft_rst_1), .soft_rst_2(soft_rst_2),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sop(out_sop), .out_eop(out_eop), .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic refreshFifos();
        fifo_empty_0 = (q0.size() == 0);
        fifo_empty_1 = (q1.size() == 0);
        fifo_empty_2 = (q2.size() == 0);
        fifo_dout_0  = (q0.size() != 0) ? q0[0] : 8'h00;
        fifo_dout_1  = (q1.size() != 0) ? q1[0] : 8'h00;
        fifo_dout_2  = (q2.size() != 0) ? q2[0] : 8'h00;
    endtask

    task automatic pushByte(input int f, input logic [7:0] b);
        case (f)
            0: q0.push_back(b);
            1: q1.push_back(b);
            default: q2.push_back(b);
        endcase
        refreshFifos();
    endtask

    // Advance one clock; pops follow the rd_en values seen just before the edge.
    task automatic applyStimulus();
        logic [2:0] pops;
        #1;
        pops = {rd_en_2, rd_en_1, rd_en_0};
        @(posedge clk);
        #1;
        if (pops[0] && q0.size() != 0) void'(q0.pop_front());
        if (pops[1] && q1.size() != 0) void'(q1.pop_front());
        if (pops[2] && q2.size() != 0) void'(q2.pop_front());
        refreshFifos();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " grant"}, 32'(grant), 32'd0);
        checkOutput({tag, " busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " out_data"}, 32'(out_data), 32'd0);
        checkOutput({tag, " sop_eop"}, 32'({out_sop, out_eop}), 32'd0);
        checkOutput({tag, " rd_en"}, 32'({rd_en_2, rd_en_1, rd_en_0}), 32'd0);
        checkOutput({tag, " soft_rst"}, 32'({soft_rst_2, soft_rst_1, soft_rst_0}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] pkt1[5];
        logic [7:0] rrBytes[4][3];
        logic [2:0] rrGrant[4];

        testsRun    = 0;
        testsFailed = 0;
        rst         = 1'b1;
        out_ready   = 1'b0;
        refreshFifos();
        @(posedge clk);
        #2;
        checkAllZero("reset");
        rst = 1'b0;
        #1;

        // Single L=3 packet from FIFO0
        pkt1 = '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h5E};
        for (int i = 0; i < 5; i++) pushByte(0, pkt1[i]);
        out_ready = 1'b1;
        #1;
        checkOutput("t1 grant before", 32'(grant), 32'd0);
        applyStimulus();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t1 grant b%0d", i), 32'(grant), 32'b001);
            checkOutput($sformatf("t1 data b%0d", i), 32'(out_data), 32'(pkt1[i]));
            checkOutput($sformatf("t1 valid b%0d", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("t1 sop b%0d", i), 32'(out_sop), 32'(i == 0));
            checkOutput($sformatf("t1 eop b%0d", i), 32'(out_eop), 32'(i == 4));
            checkOutput($sformatf("t1 rd_en b%0d", i), 32'({rd_en_2, rd_en_1, rd_en_0}), 32'b001);
            applyStimulus();
        end
        checkOutput("t1 grant after", 32'(grant), 32'd0);
        checkOutput("t1 busy after", 32'(busy), 32'd0);

        // Round robin from reset: FIFO0, FIFO1, FIFO2, FIFO0 with one idle bubble each
        rst = 1'b1;
        #1;
        applyStimulus();
        rst = 1'b0;
        #1;
        rrBytes = '{'{8'h04, 8'h10, 8'h11}, '{8'h05, 8'h20, 8'h21},
                    '{8'h06, 8'h30, 8'h31}, '{8'h04, 8'h40, 8'h41}};
        rrGrant = '{3'b001, 3'b010, 3'b100, 3'b001};
        for (int j = 0; j < 3; j++) pushByte(0, rrBytes[0][j]);
        for (int j = 0; j < 3; j++) pushByte(1, rrBytes[1][j]);
        for (int j = 0; j < 3; j++) pushByte(2, rrBytes[2][j]);
        for (int j = 0; j < 3; j++) pushByte(0, rrBytes[3][j]);
        #1;
        applyStimulus();
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 3; j++) begin
                checkOutput($sformatf("t2 grant p%0d b%0d", p, j), 32'(grant), 32'(rrGrant[p]));
                checkOutput($sformatf("t2 data p%0d b%0d", p, j), 32'(out_data), 32'(rrBytes[p][j]));
                applyStimulus();
            end
            checkOutput($sformatf("t2 bubble p%0d", p), 32'({busy, grant}), 32'd0);
            applyStimulus();
        end

        // Zero-length packet on FIFO1 (rr pointer now at FIFO0)
        pushByte(1, 8'h01);
        pushByte(1, 8'h77);
        #1;
        applyStimulus();
        checkOutput("t3 grant", 32'(grant), 32'b010);
        checkOutput("t3 hdr", 32'({out_data, out_sop, out_eop, rd_en_1}), {8'h01, 3'b101});
        applyStimulus();
        checkOutput("t3 parity", 32'({out_data, out_sop, out_eop, rd_en_1}), {8'h77, 3'b011});
        applyStimulus();
        checkOutput("t3 idle", 32'({busy, grant}), 32'd0);

        // 29 stalled cycles mid-payload on FIFO2 must not time out
        pushByte(2, 8'h08);
        pushByte(2, 8'hB1);
        pushByte(2, 8'hB2);
        pushByte(2, 8'hB3);
        #1;
        applyStimulus();
        checkOutput("t4 grant", 32'(grant), 32'b100);
        applyStimulus();
        out_ready = 1'b0;
        #1;
        for (int s = 0; s < 29; s++) begin
            checkOutput($sformatf("t4 stall %0d", s),
                        32'({out_valid, rd_en_2, soft_rst_2, soft_rst_1, soft_rst_0, out_data}),
                        {5'b10000, 8'hB1});
            applyStimulus();
        end
        checkOutput("t4 soft_rst after 29", 32'({soft_rst_2, soft_rst_1, soft_rst_0}), 32'd0);
        checkOutput("t4 grant held", 32'(grant), 32'b100);
        out_ready = 1'b1;
        #1;
        checkOutput("t4 resume B1", 32'({out_data, rd_en_2}), {8'hB1, 1'b1});
        applyStimulus();
        checkOutput("t4 B2", 32'(out_data), 32'h0B2);
        applyStimulus();
        checkOutput("t4 B3 eop", 32'({out_data, out_eop}), {8'hB3, 1'b1});
        applyStimulus();
        checkOutput("t4 done", 32'({busy, grant, soft_rst_2}), 32'd0);

        // Timeout on FIFO2 after 30 stalled cycles, then FIFO0 wins
        out_ready = 1'b0;
        pushByte(2, 8'h0C);
        pushByte(2, 8'hC1);
        #1;
        applyStimulus();
        pushByte(0, 8'h00);
        pushByte(0, 8'h99);
        #1;
        for (int s = 1; s <= 30; s++) begin
            checkOutput($sformatf("t5 grant s%0d", s), 32'({grant, soft_rst_2, rd_en_2}), {3'b100, 2'b00});
            applyStimulus();
        end
        checkOutput("t5 soft_rst", 32'({soft_rst_2, soft_rst_1, soft_rst_0}), 32'b100);
        checkOutput("t5 grant cleared", 32'({busy, grant}), 32'd0);
        q2.delete();
        refreshFifos();
        #1;
        applyStimulus();
        checkOutput("t5 pulse width", 32'({soft_rst_2, soft_rst_1, soft_rst_0}), 32'd0);
        checkOutput("t5 next grant", 32'(grant), 32'b001);
        out_ready = 1'b1;
        #1;
        checkOutput("t5 hdr", 32'({out_data, out_sop}), {8'h00, 1'b1});
        applyStimulus();
        checkOutput("t5 parity", 32'({out_data, out_eop}), {8'h99, 1'b1});
        applyStimulus();

        // FIFO1 underflows mid-payload for 40 cycles, then resumes
        pushByte(1, 8'h0C);
        pushByte(1, 8'hD1);
        #1;
        applyStimulus();
        checkOutput("t6 grant", 32'(grant), 32'b010);
        applyStimulus();
        checkOutput("t6 D1", 32'(out_data), 32'h0D1);
        applyStimulus();
        for (int s = 0; s < 40; s++) begin
            checkOutput($sformatf("t6 empty %0d", s),
                        32'({busy, grant, out_valid, rd_en_1, soft_rst_2, soft_rst_1, soft_rst_0}),
                        {1'b1, 3'b010, 5'b00000});
            applyStimulus();
        end
        pushByte(1, 8'hD2);
        pushByte(1, 8'hD3);
        pushByte(1, 8'hE0);
        #1;
        checkOutput("t6 D2", 32'({out_valid, out_data}), {1'b1, 8'hD2});
        applyStimulus();
        checkOutput("t6 D3", 32'({out_valid, out_data}), {1'b1, 8'hD3});

        // Asynchronous reset mid-packet, then FIFO0 takes priority
        rst = 1'b1;
        #1;
        checkAllZero("t6 async rst");
        applyStimulus();
        pushByte(0, 8'h00);
        pushByte(0, 8'h55);
        rst = 1'b0;
        #1;
        applyStimulus();
        checkOutput("t6 post-reset grant", 32'(grant), 32'b001);
        checkOutput("t6 post-reset hdr", 32'({out_data, out_sop}), {8'h00, 1'b1});
        checkOutput("t6 post-reset soft_rst", 32'({soft_rst_2, soft_rst_1, soft_rst_0}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
